// File: rtl/mat_stream_port.sv
// Initiator-side adapter for the matrix BRAM manager: streams beats into a 16x128 int8
// buffer for writes, and drains a captured matrix back out as beats for reads.
module mat_stream_port #(
  parameter int BEAT_BYTES = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic                    I_CLK,
  input  logic                    I_RST_N,
  input  logic                    I_CMD_VLD,
  output logic                    O_CMD_RDY,
  input  logic                    I_CMD_WR,
  input  logic [7:0]              I_CMD_SEL,
  input  logic                    I_WDATA_VLD,
  output logic                    O_WDATA_RDY,
  input  logic [BEAT_BYTES*8-1:0] I_WDATA,
  output logic                    O_RDATA_VLD,
  input  logic                    I_RDATA_RDY,
  output logic [BEAT_BYTES*8-1:0] O_RDATA,
  output logic                    O_RDATA_LAST,
  output logic                    O_WR_ENA_PULSE,
  output logic                    O_RD_ENA_PULSE,
  output logic [7:0]              O_SEL,
  output logic [0:15][0:127][7:0] O_MAT,
  input  logic [0:15][0:127][7:0] I_MAT,
  input  logic                    I_VLD,
  input  logic                    I_WR_DONE,
  output logic                    O_BUSY,
  output logic                    O_ERR
);
  localparam int BPR   = 128 / BEAT_BYTES;
  localparam int NBEAT = 16 * BPR;
  localparam int CNT_W = $clog2(NBEAT);
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DRAIN
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         beat_cnt_reg;
  logic [TMR_W-1:0]         timer_reg;
  logic                     armed_reg;
  logic [7:0]               sel_reg;
  logic                     err_reg;
  logic [0:15][0:127][7:0]  mat_reg;

  logic                     wait_level;
  logic                     complete;
  logic                     timed_out;
  logic                     is_last;
  logic [3:0]               row_idx;
  logic [6:0]               col_base;

  assign is_last  = (beat_cnt_reg == CNT_W'(NBEAT - 1));
  assign row_idx  = 4'(int'(beat_cnt_reg) / BPR);
  assign col_base = 7'((int'(beat_cnt_reg) % BPR) * BEAT_BYTES);

  assign O_CMD_RDY      = (state_reg == S_IDLE);
  assign O_WDATA_RDY    = (state_reg == S_FILL);
  assign O_WR_ENA_PULSE = (state_reg == S_WR_REQ);
  assign O_RD_ENA_PULSE = (state_reg == S_RD_REQ);
  assign O_RDATA_VLD    = (state_reg == S_DRAIN);
  assign O_RDATA_LAST   = (state_reg == S_DRAIN) && is_last;
  assign O_BUSY         = (state_reg != S_IDLE);
  assign O_SEL          = sel_reg;
  assign O_ERR          = err_reg;
  assign O_MAT          = mat_reg;

  // Outside S_DRAIN the read beat is forced to zero so idle/reset outputs stay quiet.
  for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_rbyte
    assign O_RDATA[gi*8 +: 8] = (state_reg == S_DRAIN) ?
                                mat_reg[row_idx][7'(int'(col_base) + gi)] : 8'h00;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_level = 1'b0;
    complete   = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (I_CMD_VLD) state_next = I_CMD_WR ? S_FILL : S_RD_REQ;
      end
      S_FILL: begin
        if (I_WDATA_VLD && is_last) state_next = S_WR_REQ;
      end
      S_WR_REQ: state_next = S_WR_WAIT;
      S_RD_REQ: state_next = S_RD_WAIT;
      S_WR_WAIT, S_RD_WAIT: begin
        // A level still high from the previous transfer only counts after it drops.
        wait_level = (state_reg == S_WR_WAIT) ? I_WR_DONE : I_VLD;
        complete   = armed_reg && wait_level;
        timed_out  = !complete && (timer_reg == TMR_W'(TIMEOUT - 1));
        if (complete) begin
          state_next = (state_reg == S_WR_WAIT) ? S_IDLE : S_DRAIN;
        end else if (timed_out) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (I_RDATA_RDY && is_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      beat_cnt_reg <= '0;
      timer_reg    <= '0;
      armed_reg    <= 1'b0;
      sel_reg      <= 8'h00;
      err_reg      <= 1'b0;
      mat_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (I_CMD_VLD) begin
            sel_reg      <= I_CMD_SEL;
            err_reg      <= 1'b0;
            beat_cnt_reg <= '0;
          end
        end
        S_FILL: begin
          if (I_WDATA_VLD) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
              mat_reg[row_idx][7'(int'(col_base) + b)] <= I_WDATA[b*8 +: 8];
            end
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          timer_reg <= '0;
          armed_reg <= 1'b0;
        end
        S_WR_WAIT, S_RD_WAIT: begin
          timer_reg <= timer_reg + TMR_W'(1);
          if (!wait_level) armed_reg <= 1'b1;
          if (timed_out) err_reg <= 1'b1;
          if (complete && (state_reg == S_RD_WAIT)) begin
            mat_reg      <= I_MAT;
            beat_cnt_reg <= '0;
          end
        end
        S_DRAIN: begin
          if (I_RDATA_RDY) beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_stream_port.sv
// Self-checking bench for mat_stream_port: table of transactions, hand-built corner
// sequences and random transactions checked against a matrix-level reference model.
module tb_mat_stream_port;
  localparam int BB    = 16;
  localparam int TO    = 32;
  localparam int BPR   = 128 / BB;
  localparam int NBEAT = 16 * BPR;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cmd_vld, cmd_rdy, cmd_wr;
  logic [7:0]              cmd_sel;
  logic                    wdata_vld, wdata_rdy;
  logic [BB*8-1:0]         wdata;
  logic                    rdata_vld, rdata_rdy, rdata_last;
  logic [BB*8-1:0]         rdata;
  logic                    wr_pulse, rd_pulse;
  logic [7:0]              sel;
  logic [0:15][0:127][7:0] o_mat, i_mat;
  logic                    vld, wr_done, busy, err;

  always #5 clk = ~clk;

  mat_stream_port #(.BEAT_BYTES(BB), .TIMEOUT(TO)) dut (
    .I_CLK(clk), .I_RST_N(rst_n),
    .I_CMD_VLD(cmd_vld), .O_CMD_RDY(cmd_rdy), .I_CMD_WR(cmd_wr), .I_CMD_SEL(cmd_sel),
    .I_WDATA_VLD(wdata_vld), .O_WDATA_RDY(wdata_rdy), .I_WDATA(wdata),
    .O_RDATA_VLD(rdata_vld), .I_RDATA_RDY(rdata_rdy), .O_RDATA(rdata), .O_RDATA_LAST(rdata_last),
    .O_WR_ENA_PULSE(wr_pulse), .O_RD_ENA_PULSE(rd_pulse), .O_SEL(sel),
    .O_MAT(o_mat), .I_MAT(i_mat), .I_VLD(vld), .I_WR_DONE(wr_done),
    .O_BUSY(busy), .O_ERR(err)
  );

  typedef struct {
    bit         wr;
    logic [7:0] sel;
    int         pat;      // 0: (r*128+c), 1: (r+c), 2: random
    int         stale;    // cycles after the pulse the manager level is held high
    int         low;      // then cycles held low, then high for good
    bit         gaps;
    int         rmode;    // 0: always ready, 1: toggle, 2: random
    bit         exp_err;
    int         exp_lat;  // cycles from pulse to idle (write/timeout) or first read beat
  } vec_t;

  int         total = 0;
  int         bad = 0;
  bit         last_err = 1'b0;
  string      cur = "init";
  logic [7:0] model_mat [16][128];
  logic [7:0] new_mat   [16][128];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h want %0h", cur, name, act, exp);
    end
  endfunction

  task automatic mat_chk(string name);
    int nd = 0, fr = 0, fc = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 128; c++)
        if (o_mat[r][c] !== model_mat[r][c]) begin
          if (nd == 0) begin fr = r; fc = c; end
          nd++;
        end
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL %s/%s: %0d bytes differ, first [%0d][%0d] got %0h want %0h",
               cur, name, nd, fr, fc, o_mat[fr][fc], model_mat[fr][fc]);
    end
  endtask

  task automatic gen_pat(int pat);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 128; c++)
        new_mat[r][c] = (pat == 0) ? 8'((r * 128 + c) & 255) :
                        (pat == 1) ? 8'((r + c) & 255) : 8'($urandom);
  endtask

  function automatic logic [BB*8-1:0] beat_new(int k);
    logic [BB*8-1:0] v;
    for (int b = 0; b < BB; b++) v[b*8 +: 8] = new_mat[k / BPR][(k % BPR) * BB + b];
    return v;
  endfunction

  function automatic logic [BB*8-1:0] beat_model(int k);
    logic [BB*8-1:0] v;
    for (int b = 0; b < BB; b++) v[b*8 +: 8] = model_mat[k / BPR][(k % BPR) * BB + b];
    return v;
  endfunction

  function automatic bit lvl(int stale, int low, int j);
    if (j <= stale) return 1'b1;
    if (j <= stale + low) return 1'b0;
    return 1'b1;
  endfunction

  // Walks the manager's level cycle by cycle after the pulse: done needs a low then a high.
  function automatic void ref_wait(int stale, int low, output int lat, output bit e);
    bit seen_low = 1'b0;
    for (int j = 1; j <= TO; j++) begin
      if (seen_low && lvl(stale, low, j)) begin lat = j + 1; e = 1'b0; return; end
      if (!lvl(stale, low, j)) seen_low = 1'b1;
    end
    lat = TO + 1;
    e = 1'b1;
  endfunction

  task automatic check_reset(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_wpulse"}, wr_pulse, 0);
    chk({tag, "_rpulse"}, rd_pulse, 0);
    chk({tag, "_rvld"}, rdata_vld, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rlast"}, rdata_last, 0);
    chk({tag, "_wrdy"}, wdata_rdy, 0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 128; c++) model_mat[r][c] = 8'h00;
    mat_chk({tag, "_mat"});
  endtask

  // Starts and ends at the drive point (1 time unit after a rising edge).
  task automatic do_txn(string tag, vec_t v, bit hold, bit pre, int abort_at);
    int k, cyc, j, guard, extra, rdy_busy;
    logic [BB*8-1:0] prev;
    bit prev_stall;
    cur = $sformatf("%s sel=%02h", tag, v.sel);
    extra = 0;
    rdy_busy = 0;
    gen_pat(v.pat);
    if (!v.wr)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 128; c++) i_mat[r][c] = new_mat[r][c];
    if (!pre) begin
      cmd_vld = 1'b1; cmd_wr = v.wr; cmd_sel = v.sel;
      guard = 0;
      @(negedge clk);
      while (!cmd_rdy && guard < 20) begin @(posedge clk); #1; @(negedge clk); guard++; end
      chk("cmd_rdy", cmd_rdy, 1);
      chk("err_sticky", err, last_err);
      @(posedge clk); #1;
    end
    cmd_vld = hold;

    if (v.wr) begin
      k = 0; cyc = 0;
      while (k < NBEAT && cyc < 2000) begin
        wdata_vld = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        wdata = beat_new(k);
        @(negedge clk);
        if (cyc == 0) begin
          chk("wrdy_t1", wdata_rdy, 1);
          chk("err_clr", err, 0);
          chk("sel", sel, v.sel);
        end
        if (cmd_rdy) rdy_busy++;
        if (wr_pulse || rd_pulse) extra++;
        if (wdata_vld && wdata_rdy) k++;
        cyc++;
        if (abort_at > 0 && k == abort_at) begin
          rst_n = 1'b0; wdata_vld = 1'b0; cmd_vld = 1'b0;
          #1;
          check_reset("midrst");
          @(posedge clk); #1;
          rst_n = 1'b1;
          @(negedge clk);
          chk("rst_cmd_rdy", cmd_rdy, 1);
          last_err = 1'b0;
          $display("txn %s: reset after %0d beats", cur, k);
          @(posedge clk); #1;
          return;
        end
        @(posedge clk); #1;
      end
      wdata_vld = 1'b0;
      if (!v.gaps) chk("fill_cycles", cyc, NBEAT);
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 128; c++) model_mat[r][c] = new_mat[r][c];
      @(negedge clk);
      chk("wr_pulse", wr_pulse, 1);
    end else begin
      @(negedge clk);
      chk("rd_pulse", rd_pulse, 1);
      chk("err_clr", err, 0);
      chk("sel", sel, v.sel);
      rdata_rdy = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    j = 0;
    while (j < 100) begin
      @(posedge clk); #1;
      j++;
      if (v.wr) wr_done = lvl(v.stale, v.low, j);
      else      vld     = lvl(v.stale, v.low, j);
      @(negedge clk);
      if (wr_pulse || rd_pulse) extra++;
      if (j < v.exp_lat && cmd_rdy) rdy_busy++;
      if (!busy || rdata_vld) break;
    end
    chk("latency", j, v.exp_lat);
    chk("err", err, v.exp_err);
    chk("one_pulse", extra, 0);

    if (!v.wr && v.exp_err) chk("no_rvld", rdata_vld, 0);
    if (!v.wr && !v.exp_err) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 128; c++) model_mat[r][c] = new_mat[r][c];
      k = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
      while (k < NBEAT && cyc < 1000) begin
        chk("rvld", rdata_vld, 1);
        chk($sformatf("rdata%0d", k), rdata, beat_model(k));
        chk("rlast", rdata_last, (k == NBEAT - 1));
        if (prev_stall) chk("rhold", rdata, prev);
        if (cmd_rdy) rdy_busy++;
        prev = rdata;
        prev_stall = !rdata_rdy;
        if (rdata_rdy) k++;
        cyc++;
        @(posedge clk); #1;
        rdata_rdy = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? !rdata_rdy : 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk("beats", k, NBEAT);
      if (v.rmode == 0) chk("drain_cycles", cyc, NBEAT);
      chk("rvld_end", rdata_vld, 0);
    end

    chk("idle", busy, 0);
    chk("cmd_rdy_idle", cmd_rdy, 1);
    chk("rdy_while_busy", rdy_busy, 0);
    mat_chk("mat");
    last_err = v.exp_err;
    $display("txn %s %s: latency=%0d err=%0b", cur, v.wr ? "wr" : "rd", j, err);
    rdata_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl [8];
  vec_t rv;
  int   r_lat;
  bit   r_err;

  initial begin
    tbl[0] = '{1'b1, 8'h05, 0, 0,    3,    1'b0, 0, 1'b0, 5};
    tbl[1] = '{1'b1, 8'h5A, 2, 3,    1,    1'b0, 0, 1'b0, 6};
    tbl[2] = '{1'b0, 8'h21, 1, 0,    2,    1'b0, 1, 1'b0, 4};
    tbl[3] = '{1'b0, 8'h33, 2, 2,    1,    1'b0, 2, 1'b0, 5};
    tbl[4] = '{1'b0, 8'h44, 2, 0,    1000, 1'b0, 0, 1'b1, 33};
    tbl[5] = '{1'b1, 8'h77, 2, 0,    5,    1'b1, 0, 1'b0, 7};
    tbl[6] = '{1'b1, 8'h10, 2, 1000, 0,    1'b0, 0, 1'b1, 33};
    tbl[7] = '{1'b0, 8'h21, 2, 0,    1,    1'b0, 0, 1'b0, 3};

    cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_sel = 8'h00;
    wdata_vld = 1'b0; wdata = '0; rdata_rdy = 1'b0;
    i_mat = '0; vld = 1'b0; wr_done = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_cmd_rdy", cmd_rdy, 1);
    @(posedge clk); #1;

    do_txn("abort", tbl[0], 1'b0, 1'b0, 40);

    for (int i = 0; i < 8; i++) do_txn($sformatf("tbl%0d", i), tbl[i], 1'b0, 1'b0, 0);

    // Command held valid across a whole write; the repeat is taken only once idle.
    do_txn("hold1", '{1'b1, 8'h66, 2, 0, 2, 1'b0, 0, 1'b0, 4}, 1'b1, 1'b0, 0);
    do_txn("hold2", '{1'b1, 8'h66, 2, 2, 1, 1'b0, 0, 1'b0, 5}, 1'b0, 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      rv.wr    = 1'($urandom_range(0, 1));
      rv.sel   = 8'($urandom);
      rv.pat   = 2;
      rv.stale = $urandom_range(0, 4);
      rv.low   = ($urandom_range(0, 4) == 0) ? 1000 : $urandom_range(1, 6);
      rv.gaps  = 1'($urandom_range(0, 1));
      rv.rmode = 2;
      ref_wait(rv.stale, rv.low, r_lat, r_err);
      rv.exp_lat = r_lat;
      rv.exp_err = r_err;
      do_txn($sformatf("rnd%0d", i), rv, 1'b0, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_stream_port.md
# mat_stream_port

Initiator-side adapter for the matrix BRAM manager in the attention datapath. It accepts read/write commands for one 16x128 int8 matrix slot. For writes, it assembles a narrow beat stream into a full matrix register, issues one write pulse and waits for write-done. For reads, it issues one read pulse, captures the returned matrix on valid and serialises it back out as a beat stream.

## Interface
Parameters:
- BEAT_BYTES, 16, bytes per stream beat; must divide 128. BPR = 128/BEAT_BYTES beats per row; NBEAT = 16*BPR beats per matrix (128 at default).
- TIMEOUT, 32, maximum cycles spent in a wait state before error.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RST_N  in  1  reset, asynchronous, active-low.
- I_CMD_VLD  in  1  command valid.
- O_CMD_RDY  out  1  command ready; combinational, high only in S_IDLE.
- I_CMD_WR  in  1  1 = write, 0 = read.
- I_CMD_SEL  in  8  matrix slot address.
- I_WDATA_VLD  in  1  write beat valid.
- O_WDATA_RDY  out  1  write beat ready; combinational, high only in S_FILL.
- I_WDATA  in  BEAT_BYTES*8  write beat; byte b is I_WDATA[b*8+:8].
- O_RDATA_VLD  out  1  read beat valid.
- I_RDATA_RDY  in  1  read beat ready.
- O_RDATA  out  BEAT_BYTES*8  read beat, same byte layout as I_WDATA.
- O_RDATA_LAST  out  1  marks beat NBEAT-1.
- O_WR_ENA_PULSE  out  1  one-cycle write request to the manager.
- O_RD_ENA_PULSE  out  1  one-cycle read request to the manager.
- O_SEL  out  8  slot address to the manager.
- O_MAT  out  [0:15][0:127] x 8  matrix buffer, driven to the manager.
- I_MAT  in  [0:15][0:127] x 8  matrix returned by the manager.
- I_VLD  in  1  manager read valid; a level, held until the next read.
- I_WR_DONE  in  1  manager write done; a level, held until the next write.
- O_BUSY  out  1  high whenever the state is not S_IDLE.
- O_ERR  out  1  sticky timeout flag.

## Operation
- Beat mapping is row-major. Beat k carries row k/BPR, columns (k%BPR)*BEAT_BYTES + b for b = 0..BEAT_BYTES-1.
- A single 16x128 register serves as the buffer; O_MAT is that register. It changes only on accepted write beats, on read capture, or on reset. It is held stable through the whole write handshake.
- S_IDLE: on I_CMD_VLD & O_CMD_RDY:
  - latch I_CMD_SEL into O_SEL; clear O_ERR.
  - if I_CMD_WR = 1 → S_FILL with beat_cnt = 0; otherwise → S_RD_REQ.
- S_FILL: each I_WDATA_VLD & O_WDATA_RDY writes one beat into the buffer and increments beat_cnt. Acceptance of beat NBEAT-1 → S_WR_REQ.
- S_WR_REQ: O_WR_ENA_PULSE = 1 for exactly this cycle → S_WR_WAIT; clear timer and the `armed` flag.
- S_WR_WAIT:
  - if I_WR_DONE = 0, set `armed`.
  - if `armed` & I_WR_DONE = 1 → S_IDLE.
  - A done level left over from a previous write never completes the handshake; it must drop low first.
- S_RD_REQ: O_RD_ENA_PULSE = 1 for exactly this cycle → S_RD_WAIT; clear timer and `armed`.
- S_RD_WAIT: same armed rule applied to I_VLD. On completion, capture I_MAT into the buffer → S_DRAIN with beat_cnt = 0.
- S_DRAIN:
  - O_RDATA_VLD = 1; O_RDATA = buffer beat beat_cnt; O_RDATA_LAST = (beat_cnt == NBEAT-1).
  - When I_RDATA_RDY is low, data and last are held.
  - Acceptance of the last beat → S_IDLE.
- Timeout: the timer increments in every WAIT cycle. If it reaches TIMEOUT-1 without completion: set O_ERR, go to S_IDLE. The buffer is not captured and no drain occurs.
- Completion and timeout in the same cycle: completion wins; O_ERR stays 0.
- I_CMD_VLD outside S_IDLE is ignored. Pulses are never issued back-to-back.

## Timing
- Reset values: state S_IDLE, O_MAT all 0, O_SEL 0, both pulses 0, O_RDATA_VLD 0, O_RDATA 0, O_RDATA_LAST 0, O_ERR 0, O_BUSY 0. O_CMD_RDY is 1 once reset is released.
- Reset mid-operation: immediate return to the reset values. Any partial beat_cnt, timer or buffer contents are discarded.
- Write latency: command accepted at cycle t.
  - O_WDATA_RDY is high from t+1.
  - With back-to-back beats, the last beat is accepted at t+NBEAT.
  - The pulse is issued at t+NBEAT+1.
  - Return to S_IDLE occurs one cycle after I_WR_DONE is sampled high while armed.
- Read latency: command accepted at t; pulse at t+1. The first beat is valid the cycle after I_VLD is sampled high while armed. At full throughput there is one beat per cycle.
- beat_cnt is log2(NBEAT) bits and wraps only on exit from the state. The timer is $clog2(TIMEOUT) bits.

## Test plan
- Reset: assert I_RST_N low mid-S_FILL at beat 40 → every output at its reset value. After release, O_CMD_RDY = 1 and a new write completes normally.
- Write: SEL = 0x05, 128 beats with byte (row*128+col)&0xFF, manager model drops I_WR_DONE then raises it 4 cycles after the pulse → exactly one O_WR_ENA_PULSE with O_SEL = 0x05; O_MAT[r][c] = (r*128+c)&0xFF; O_ERR = 0; back to S_IDLE.
- Stale done: I_WR_DONE held at 1 from the previous write, model keeps it high for 3 cycles after the pulse, then low 1 cycle, then high → completion occurs only after the low-then-high sequence.
- Read with backpressure: SEL = 0x21, I_MAT[r][c] = (r+c)&0xFF, I_RDATA_RDY toggling every cycle → 128 beats in order; O_RDATA stable while not ready; O_RDATA_LAST only on beat 127.
- Timeout: manager model never responds to a read → O_ERR = 1 after TIMEOUT WAIT cycles; no O_RDATA_VLD; O_MAT unchanged. The next accepted command clears O_ERR.
- Command blocking: hold I_CMD_VLD high throughout a write → O_CMD_RDY is low until S_IDLE; the second command is accepted only then.
